// File: rtl/demux12_pkt.sv
// Packet-aware 1-to-2 stream demultiplexer. The route select is sampled on a
// packet's first beat and held until LAST; each output is buffered in its own FIFO.
module demux12_pkt #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       CLK,
   input  logic                       RSTB,
   input  logic [WIDTH-1:0]           IN,
   input  logic                       IN_LAST,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   input  logic                       S,
   output logic [WIDTH-1:0]           Q1,
   output logic [WIDTH-1:0]           Q2,
   output logic                       Q1_LAST,
   output logic                       Q2_LAST,
   output logic                       Q1_VALID,
   output logic                       Q2_VALID,
   input  logic                       Q1_READY,
   input  logic                       Q2_READY,
   output logic [$clog2(DEPTH+1)-1:0] CNT1,
   output logic [$clog2(DEPTH+1)-1:0] CNT2
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK1 = 2'd1,
      ST_LOCK2 = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   target;
   logic   accept;

   logic [1:0]                 out_ready;
   logic [1:0]                 push;
   logic [1:0]                 pop;
   logic [1:0]                 full;
   logic [1:0]                 nonempty;
   logic [1:0][WIDTH-1:0]      head_data;
   logic [1:0]                 head_last;
   logic [1:0][CW-1:0]         count;

   assign out_ready = {Q2_READY, Q1_READY};

   // Route FSM: S steers only in IDLE; a lock holds the target until LAST.
   always_comb begin
      state_d = state_q;
      target  = S;
      case (state_q)
         ST_LOCK1: target = 1'b0;
         ST_LOCK2: target = 1'b1;
         default:  target = S;
      endcase
      IN_READY = RSTB && !full[target];
      accept   = IN_VALID && IN_READY;
      if (accept) begin
         if (IN_LAST) begin
            state_d = ST_IDLE;
         end else if (state_q == ST_IDLE) begin
            state_d = target ? ST_LOCK2 : ST_LOCK1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTB) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [WIDTH:0]  mem_q [DEPTH];
      logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
      logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]   cnt_q, cnt_d;

      assign push[gi]     = accept && (target == 1'(gi));
      assign pop[gi]      = (cnt_q != '0) && out_ready[gi];
      assign full[gi]     = (cnt_q == FULL_CNT);
      assign nonempty[gi] = (cnt_q != '0);
      assign count[gi]    = cnt_q;

      // Head is read straight from storage; masked while empty so reset shows zeros.
      assign head_data[gi] = nonempty[gi] ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
      assign head_last[gi] = nonempty[gi] ? mem_q[rd_ptr_q][WIDTH] : 1'b0;

      always_comb begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         cnt_d    = cnt_q;
         if (push[gi]) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop[gi]) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push[gi] && !pop[gi]) begin
            cnt_d = cnt_q + 1'b1;
         end else if (!push[gi] && pop[gi]) begin
            cnt_d = cnt_q - 1'b1;
         end
      end

      always_ff @(posedge CLK) begin
         if (!RSTB) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
         end
      end

      always_ff @(posedge CLK) begin
         if (push[gi]) begin
            mem_q[wr_ptr_q] <= {IN_LAST, IN};
         end
      end
   end

   assign Q1       = head_data[0];
   assign Q2       = head_data[1];
   assign Q1_LAST  = head_last[0];
   assign Q2_LAST  = head_last[1];
   assign Q1_VALID = nonempty[0];
   assign Q2_VALID = nonempty[1];
   assign CNT1     = count[0];
   assign CNT2     = count[1];

endmodule

// File: tb/tb_demux12_pkt.sv
// Bench for demux12_pkt: directed scenarios then random traffic, every cycle
// compared against a queue-based model of routing and buffering.
module tb_demux12_pkt;

   localparam int WIDTH = 8;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             CLK = 1'b0;
   logic             RSTB;
   logic [WIDTH-1:0] IN;
   logic             IN_LAST;
   logic             IN_VALID;
   logic             IN_READY;
   logic             S;
   logic [WIDTH-1:0] Q1, Q2;
   logic             Q1_LAST, Q2_LAST;
   logic             Q1_VALID, Q2_VALID;
   logic             Q1_READY, Q2_READY;
   logic [CW-1:0]    CNT1, CNT2;

   int tests = 0;
   int fails = 0;

   // Model: one queue of {last, data} per output; route = -1 when between packets.
   logic [WIDTH:0] mq1[$];
   logic [WIDTH:0] mq2[$];
   int             route = -1;

   demux12_pkt #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RSTB(RSTB), .IN(IN), .IN_LAST(IN_LAST), .IN_VALID(IN_VALID),
      .IN_READY(IN_READY), .S(S), .Q1(Q1), .Q2(Q2), .Q1_LAST(Q1_LAST),
      .Q2_LAST(Q2_LAST), .Q1_VALID(Q1_VALID), .Q2_VALID(Q2_VALID),
      .Q1_READY(Q1_READY), .Q2_READY(Q2_READY), .CNT1(CNT1), .CNT2(CNT2)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("Q1_VALID", 32'(Q1_VALID), 32'(mq1.size() != 0));
      chk("Q2_VALID", 32'(Q2_VALID), 32'(mq2.size() != 0));
      chk("CNT1", 32'(CNT1), 32'(mq1.size()));
      chk("CNT2", 32'(CNT2), 32'(mq2.size()));
      chk("Q1", 32'(Q1), (mq1.size() != 0) ? 32'(mq1[0][WIDTH-1:0]) : 32'd0);
      chk("Q2", 32'(Q2), (mq2.size() != 0) ? 32'(mq2[0][WIDTH-1:0]) : 32'd0);
      chk("Q1_LAST", 32'(Q1_LAST), (mq1.size() != 0) ? 32'(mq1[0][WIDTH]) : 32'd0);
      chk("Q2_LAST", 32'(Q2_LAST), (mq2.size() != 0) ? 32'(mq2[0][WIDTH]) : 32'd0);
   endtask

   // One clock cycle with the inputs as currently driven; reports whether a beat was taken.
   task automatic step(output bit acc);
      int tgt;
      bit rdy, p1, p2;
      #1;
      tgt = (route < 0) ? int'(S) : route;
      rdy = RSTB && ((tgt == 0) ? (mq1.size() < DEPTH) : (mq2.size() < DEPTH));
      chk("IN_READY", 32'(IN_READY), 32'(rdy));
      acc = IN_VALID && rdy;
      p1  = (mq1.size() != 0) && Q1_READY;
      p2  = (mq2.size() != 0) && Q2_READY;
      @(posedge CLK);
      if (!RSTB) begin
         mq1.delete();
         mq2.delete();
         route = -1;
      end else begin
         if (p1) void'(mq1.pop_front());
         if (p2) void'(mq2.pop_front());
         if (acc) begin
            if (tgt == 0) mq1.push_back({IN_LAST, IN});
            else          mq2.push_back({IN_LAST, IN});
            route = IN_LAST ? -1 : tgt;
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit l, input bit s);
      IN_VALID = v;
      IN       = d;
      IN_LAST  = l;
      S        = s;
   endtask

   // Offers one beat until taken, bounded so a stuck IN_READY cannot hang the run.
   task automatic send(input logic [WIDTH-1:0] d, input bit l, input bit s);
      bit acc;
      int n;
      acc = 0;
      n   = 0;
      drive(1'b1, d, l, s);
      while (!acc && n < 50) begin
         step(acc);
         n++;
      end
      tests++;
      if (!acc) begin
         fails++;
         $error("FAIL send_timeout: observed no accept expected accept of %0h", d);
      end
      IN_VALID = 1'b0;
   endtask

   initial begin
      bit acc;
      RSTB = 1'b0;
      Q1_READY = 1'b0;
      Q2_READY = 1'b0;
      drive(1'b1, 8'h3C, 1'b0, 1'b1);

      // Reset and single-beat routing to Q2
      step(acc);
      step(acc);
      RSTB = 1'b1;
      Q2_READY = 1'b1;
      drive(1'b1, 8'hA5, 1'b1, 1'b1);
      step(acc);
      chk("a5_accepted", 32'(acc), 32'd1);
      chk("a5_on_Q2", 32'(Q2), 32'hA5);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      step(acc);

      // Packet lock: S changes after the first beat must not move the packet
      Q1_READY = 1'b1;
      send(8'h10, 1'b0, 1'b0);
      send(8'h11, 1'b0, 1'b1);
      send(8'h12, 1'b0, 1'b1);
      send(8'h13, 1'b1, 1'b1);
      step(acc);
      chk("lock_q2_untouched", 32'(CNT2), 32'd0);

      // Full / back-pressure on Q1
      Q1_READY = 1'b0;
      drive(1'b1, 8'h10, 1'b0, 1'b0); step(acc);
      drive(1'b1, 8'h11, 1'b0, 1'b0); step(acc);
      drive(1'b1, 8'h12, 1'b1, 1'b1); step(acc);
      chk("third_blocked", 32'(acc), 32'd0);
      chk("cnt1_full", 32'(CNT1), 32'd2);
      Q1_READY = 1'b1; step(acc);
      chk("blocked_at_pop", 32'(acc), 32'd0);
      Q1_READY = 1'b0; step(acc);
      chk("third_after_pop", 32'(acc), 32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      Q1_READY = 1'b1;
      repeat (3) step(acc);

      // Simultaneous push and pop at CNT1=1 across pointer wrap
      Q1_READY = 1'b0;
      send(8'h40, 1'b0, 1'b0);
      Q1_READY = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, 8'(8'h40 + i), 1'(i == 6), 1'b0);
         step(acc);
         chk("pushpop_cnt1", 32'(CNT1), 32'd1);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (2) step(acc);

      // Independence: Q2 full and stalled, Q1 packet passes
      Q2_READY = 1'b0;
      send(8'h70, 1'b0, 1'b1);
      send(8'h71, 1'b1, 1'b0);
      send(8'h80, 1'b0, 1'b0);
      send(8'h81, 1'b0, 1'b1);
      send(8'h82, 1'b1, 1'b1);
      chk("indep_cnt2", 32'(CNT2), 32'd2);
      step(acc);

      // Reset mid-packet in LOCK2
      Q2_READY = 1'b1;
      repeat (3) step(acc);
      Q2_READY = 1'b0;
      send(8'h90, 1'b0, 1'b1);
      send(8'h91, 1'b0, 1'b1);
      RSTB = 1'b0;
      drive(1'b1, 8'h92, 1'b1, 1'b1);
      step(acc);
      RSTB = 1'b1;
      chk("rst_cnt2", 32'(CNT2), 32'd0);
      send(8'hB0, 1'b1, 1'b0);
      chk("post_rst_q1", 32'(Q1), 32'hB0);

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         RSTB     = ($urandom_range(0, 63) != 0);
         IN_VALID = $urandom_range(0, 3) != 0;
         IN       = 8'($urandom);
         IN_LAST  = $urandom_range(0, 2) == 0;
         S        = 1'($urandom);
         Q1_READY = $urandom_range(0, 2) != 0;
         Q2_READY = $urandom_range(0, 2) != 0;
         step(acc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
